cla_seq_ctrl: RTL and testbench

CLA_SEQ_CTRL -- requirements
Module: cla_seq_ctrl

---
 rtl/cla_pkg.sv | 14 +
 rtl/cla_slice.sv | 47 ++++
 rtl/cla_seq_ctrl.sv | 111 +++++++++++
 tb/tb_cla_seq_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared FSM encoding and default geometry for the time-shared carry-lookahead adder.
package cla_pkg;

    localparam int CLA_N = 64;
    localparam int CLA_W = 16;
    localparam int CLA_K = CLA_N / CLA_W;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/cla_slice.sv
// Combinational W-bit carry-lookahead slice; each internal carry is a flat
// sum of products of lower generate/propagate terms rather than a ripple chain.
module cla_slice #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         c_msb
);

    logic [W-1:0] p;
    logic [W-1:0] g;
    logic [W:0]   c;

    assign p = a ^ b;
    assign g = a & b;

    always_comb begin
        logic acc;
        logic prod;
        // NOTE: every variable written here gets a value before any branch or
        // loop so no path leaves it unassigned, which would infer a latch.
        c    = '0;
        acc  = 1'b0;
        prod = 1'b0;
        c[0] = cin;
        for (int i = 0; i < W; i++) begin
            // NOTE: blocking assignments are required here; acc and prod are
            // built up term by term within one evaluation of the loop.
            acc  = g[i];
            prod = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc  = acc | (prod & g[j]);
                prod = prod & p[j];
            end
            c[i+1] = acc | (prod & cin);
        end
    end

    assign sum   = p ^ c[W-1:0];
    assign cout  = c[W];
    assign c_msb = c[W-1];

endmodule

// File: rtl/cla_seq_ctrl.sv
// Sequential N-bit add/subtract: one W-bit CLA slice is reused over K = N/W
// cycles, LSB chunk first, with the inter-chunk carry held in a register.
module cla_seq_ctrl
    import cla_pkg::*;
#(
    parameter int N = CLA_N,
    parameter int W = CLA_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    input  logic         in_sub,
    input  logic         in_cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_sum,
    output logic         out_cout,
    output logic         out_ovf,
    output logic         busy
);

    localparam int            K      = N / W;
    localparam int            KW     = $clog2(K);
    localparam logic [KW-1:0] K_LAST = KW'(K - 1);

    state_t        state;
    logic [N-1:0]  a_reg;
    logic [N-1:0]  b_reg;
    logic          carry;
    logic [KW-1:0] k;
    int            chunk_lsb;

    logic [W-1:0]  slice_sum;
    logic          slice_cout;
    logic          slice_c_msb;

    assign chunk_lsb = int'(k) * W;

    cla_slice #(
        .W(W)
    ) u_slice (
        .a     (a_reg[chunk_lsb +: W]),
        .b     (b_reg[chunk_lsb +: W]),
        .cin   (carry),
        .sum   (slice_sum),
        .cout  (slice_cout),
        .c_msb (slice_c_msb)
    );

    // Subtraction is a + ~b + 1: the inversion happens on capture and the +1
    // rides in on the carry register, so the datapath only ever adds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            carry     <= 1'b0;
            k         <= '0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling the
            // pre-edge values, so statement order inside this block is irrelevant.
            unique case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_reg    <= in_a;
                        b_reg    <= in_sub ? ~in_b : in_b;
                        carry    <= in_sub | in_cin;
                        k        <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    out_sum[chunk_lsb +: W] <= slice_sum;
                    carry                   <= slice_cout;
                    if (k == K_LAST) begin
                        // The slice MSB is bit N-1 only on the last chunk.
                        out_cout  <= slice_cout;
                        out_ovf   <= slice_cout ^ slice_c_msb;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cla_seq_ctrl.sv
// Self-checking bench for cla_seq_ctrl: a cycle-level arithmetic model is
// compared against the DUT on every falling edge, plus literal directed cases.
module tb_cla_seq_ctrl;

    localparam int N = 64;
    localparam int W = 16;
    localparam int K = N / W;

    typedef struct packed {
        logic [N-1:0] sum;
        logic         cout;
        logic         ovf;
    } res_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_a;
    logic [N-1:0] in_b;
    logic         in_sub;
    logic         in_cin;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cla_seq_ctrl #(
        .N(N),
        .W(W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Plain integer arithmetic: unsigned width-extended sum for sum/cout,
    // sign-extended true result for overflow (out of 64-bit signed range).
    function automatic res_t model_op(input logic [N-1:0] a, input logic [N-1:0] b,
                                      input logic sub, input logic cin);
        res_t         r;
        logic [N+1:0] s_ext;
        logic [N:0]   u;
        if (sub) begin
            u      = {1'b0, a} - {1'b0, b};
            s_ext  = {{2{a[N-1]}}, a} - {{2{b[N-1]}}, b};
            r.cout = (a >= b);
        end else begin
            u      = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
            s_ext  = {{2{a[N-1]}}, a} + {{2{b[N-1]}}, b} + {{(N+1){1'b0}}, cin};
            r.cout = u[N];
        end
        r.sum = u[N-1:0];
        r.ovf = !(s_ext[N+1:N-1] == 3'b000 || s_ext[N+1:N-1] == 3'b111);
        return r;
    endfunction

    // Timing model: an accepted op is in flight for K edges, then its result
    // is visible until an edge with out_ready consumes it.
    bit   m_busy = 1'b0;
    int   m_cnt  = 0;
    res_t m_out  = '0;
    res_t p_res  = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_cnt  <= 0;
            m_out  <= '0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy <= 1'b1;
                m_cnt  <= 0;
                p_res  <= model_op(in_a, in_b, in_sub, in_cin);
            end
        end else if (m_cnt < K) begin
            m_cnt <= m_cnt + 1;
            if (m_cnt == K - 1) m_out <= p_res;
        end else if (out_ready) begin
            m_busy <= 1'b0;
        end
    end

    always @(negedge clk) begin
        check("in_ready", 64'(in_ready), 64'(!m_busy));
        check("busy", 64'(busy), 64'(m_busy));
        check("out_valid", 64'(out_valid), 64'(m_busy && m_cnt == K));
        check("out_cout", 64'(out_cout), 64'(m_out.cout));
        check("out_ovf", 64'(out_ovf), 64'(m_out.ovf));
        if (!(m_busy && m_cnt < K)) check("out_sum", out_sum, m_out.sum);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_junk;
        in_valid = 1'($urandom_range(0, 1));
        in_a     = {$urandom, $urandom};
        in_b     = {$urandom, $urandom};
        in_sub   = 1'($urandom_range(0, 1));
        in_cin   = 1'($urandom_range(0, 1));
    endtask

    task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic sub,
                         input logic cin, input int hold, input bit junk,
                         output res_t r, output int lat);
        int guard = 0;
        while (!in_ready && guard < 20) begin
            tick;
            guard++;
        end
        if (guard == 20) check("in_ready_timeout", 64'(in_ready), 64'd1);
        in_a     = a;
        in_b     = b;
        in_sub   = sub;
        in_cin   = cin;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            if (junk) drive_junk;
            tick;
            lat++;
        end
        if (lat == 20) check("out_valid_timeout", 64'(out_valid), 64'd1);
        r.sum  = out_sum;
        r.cout = out_cout;
        r.ovf  = out_ovf;
        for (int h = 0; h < hold; h++) begin
            if (junk) drive_junk;
            tick;
            check("hold_in_ready", 64'(in_ready), 64'd0);
            check("hold_out_valid", 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        tick;
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        res_t r;
        int   lat;
        logic [N-1:0] a;
        logic [N-1:0] b;

        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_sub    = 1'b0;
        in_cin    = 1'b0;
        out_ready = 1'b0;

        r = model_op(64'd5, 64'd7, 1'b1, 1'b1);
        check("pin_sub_sum", r.sum, 64'hFFFF_FFFF_FFFF_FFFE);
        check("pin_sub_cout", 64'(r.cout), 64'd0);
        r = model_op(64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b0);
        check("pin_min_minus_1_sum", r.sum, 64'h7FFF_FFFF_FFFF_FFFF);
        check("pin_min_minus_1_ovf", 64'(r.ovf), 64'd1);
        check("pin_min_minus_1_cout", 64'(r.cout), 64'd1);

        #1;
        check("rst_out_sum", out_sum, 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        check("post_reset_in_ready", 64'(in_ready), 64'd1);

        do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 0, 1'b0, r, lat);
        check("d1_latency", 64'(lat), 64'd4);
        check("d1_sum", r.sum, 64'd0);
        check("d1_cout", 64'(r.cout), 64'd1);
        check("d1_ovf", 64'(r.ovf), 64'd0);

        do_op(64'h0000_0000_0000_FFFF, 64'd0, 1'b0, 1'b1, 1, 1'b0, r, lat);
        check("d2_sum", r.sum, 64'h0000_0000_0001_0000);
        check("d2_cout", 64'(r.cout), 64'd0);

        do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 0, 1'b0, r, lat);
        check("d3_sum", r.sum, 64'h8000_0000_0000_0000);
        check("d3_ovf", 64'(r.ovf), 64'd1);
        check("d3_cout", 64'(r.cout), 64'd0);

        do_op(64'd5, 64'd7, 1'b1, 1'b1, 0, 1'b0, r, lat);
        check("d4_sum", r.sum, 64'hFFFF_FFFF_FFFF_FFFE);
        check("d4_cout", 64'(r.cout), 64'd0);
        check("d4_ovf", 64'(r.ovf), 64'd0);

        do_op(64'd3, 64'd4, 1'b0, 1'b0, 3, 1'b1, r, lat);
        check("d5_sum", r.sum, 64'd7);
        check("d5_in_ready_after_release", 64'(in_ready), 64'd1);

        // Abort an operation after two RUN edges (counter at 2).
        in_a     = '1;
        in_b     = '0;
        in_sub   = 1'b0;
        in_cin   = 1'b0;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        tick;
        tick;
        #2 rst_n = 1'b0;
        #1;
        check("abort_out_sum", out_sum, 64'd0);
        check("abort_out_cout", 64'(out_cout), 64'd0);
        check("abort_out_ovf", 64'(out_ovf), 64'd0);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        check("abort_in_ready", 64'(in_ready), 64'd1);
        do_op(64'd1, 64'd2, 1'b0, 1'b0, 0, 1'b0, r, lat);
        check("d6_latency", 64'(lat), 64'd4);
        check("d6_sum", r.sum, 64'd3);

        for (int i = 0; i < 60; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0: ;
                1: a = '1;
                2: b = ~a;
                default: a = $urandom_range(0, 1) ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
            endcase
            repeat ($urandom_range(0, 2)) tick;
            do_op(a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)), r, lat);
            check("rand_latency", 64'(lat), 64'd4);
        end

        tick;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
